ldd_event_encoder: RTL

//   Transmit-side encoder for the ldd decoder code space: one-hot event lines in, 9-bit code words out.

---
 rtl/ldd_enc_pkg.sv | 15 +
 rtl/ldd_prio_sel.sv | 27 ++
 rtl/ldd_event_encoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/ldd_enc_pkg.sv
// Shared definitions for the ldd event encoder: index width derivation and code word layout.
package ldd_enc_pkg;

  localparam int IDX_LSB  = 1;
  localparam int MODE_BIT = 0;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit code_w_ok(input int n, input int cw);
    return cw >= idx_w(n) + 1;
  endfunction

endpackage

// File: rtl/ldd_prio_sel.sv
// Combinational find-first-set: lowest requesting line wins.
module ldd_prio_sel #(
  parameter int NUM_LINES = 19,
  parameter int IDX_W     = 5
) (
  input  logic [NUM_LINES-1:0] req_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o,
  output logic [NUM_LINES-1:0] onehot_o
);

  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    // Scan downward so the last hit, the lowest index, is what remains.
    for (int k = NUM_LINES - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        idx_o       = IDX_W'(k);
        onehot_o    = '0;
        onehot_o[k] = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/ldd_event_encoder.sv
// Latches one-hot event pulses into a pending mask and emits one {index, mode} word per
// accepted handshake, lowest pending line first; counts events that hit an already-pending line.
module ldd_event_encoder
  import ldd_enc_pkg::*;
#(
  parameter int NUM_LINES = 19,
  parameter int CODE_W    = 9,
  parameter int OVF_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LINES-1:0] ev_i,
  input  logic [NUM_LINES-1:0] mode_i,
  output logic [CODE_W-1:0]    code_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [NUM_LINES-1:0] pend_o,
  output logic [OVF_W-1:0]     ovf_cnt_o,
  input  logic                 clr_ovf_i,
  output logic                 idle_o
);

  localparam int IDX_W = idx_w(NUM_LINES);

  generate
    if (!code_w_ok(NUM_LINES, CODE_W)) begin : g_bad_code_w
      $error("ldd_event_encoder: CODE_W too narrow for NUM_LINES");
    end
  endgenerate

  logic [NUM_LINES-1:0] pend_q, pend_d;
  logic [NUM_LINES-1:0] pend_mode_q, pend_mode_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 valid_q, valid_d;
  logic [OVF_W-1:0]     ovf_q, ovf_d;

  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_any;
  logic [NUM_LINES-1:0] sel_oh;
  logic [NUM_LINES-1:0] sel_clr;
  logic                 load;
  logic                 overrun;

  ldd_prio_sel #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_sel (
    .req_i    (pend_q),
    .idx_o    (sel_idx),
    .any_o    (sel_any),
    .onehot_o (sel_oh)
  );

  assign load    = sel_any & (~valid_q | ready_i);
  assign sel_clr = load ? sel_oh : '0;
  assign overrun = |(ev_i & pend_q & ~sel_clr);

  always_comb begin
    // A fresh event always re-pends, even on the line being drained this cycle.
    pend_d      = ev_i | (pend_q & ~sel_clr);
    pend_mode_d = (ev_i & mode_i) | (~ev_i & pend_mode_q);

    code_d  = code_q;
    valid_d = valid_q;
    if (load) begin
      code_d                     = '0;
      code_d[IDX_LSB +: IDX_W]   = sel_idx;
      code_d[MODE_BIT]           = |(pend_mode_q & sel_oh);
      valid_d                    = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    ovf_d = ovf_q;
    if (clr_ovf_i) begin
      ovf_d = '0;
    end else if (overrun && (ovf_q != {OVF_W{1'b1}})) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_mode_q <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign code_o    = code_q;
  assign valid_o   = valid_q;
  assign pend_o    = pend_q;
  assign ovf_cnt_o = ovf_q;
  assign idle_o    = (pend_q == '0) & ~valid_q;

endmodule
